// File: rtl/tft_region_scheduler_if.sv
// Bundle of request, pixel and SPI byte-stream signals for tft_region_scheduler.
// master = scheduler side, slave = display clients plus downstream SPI byte master.
interface tft_region_scheduler_if #(
    parameter int unsigned NUM_REQ = 2
) ();
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ*9-1:0]  x0_i;
    logic [NUM_REQ*9-1:0]  x1_i;
    logic [NUM_REQ*9-1:0]  y0_i;
    logic [NUM_REQ*9-1:0]  y1_i;
    logic [NUM_REQ-1:0]    pix_valid_i;
    logic [NUM_REQ*16-1:0] pix_data_i;
    logic [NUM_REQ-1:0]    pix_ready_o;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    done_o;
    logic [NUM_REQ-1:0]    err_o;
    logic                  busy_o;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [7:0]            out_byte_o;
    logic                  out_dc_o;

    modport master (
        input  req_i, x0_i, x1_i, y0_i, y1_i, pix_valid_i, pix_data_i, out_ready_i,
        output pix_ready_o, gnt_o, done_o, err_o, busy_o, out_valid_o, out_byte_o, out_dc_o
    );

    modport slave (
        output req_i, x0_i, x1_i, y0_i, y1_i, pix_valid_i, pix_data_i, out_ready_i,
        input  pix_ready_o, gnt_o, done_o, err_o, busy_o, out_valid_o, out_byte_o, out_dc_o
    );
endinterface

// File: rtl/tft_region_scheduler.sv
// Round-robin scheduler sharing one ILI9341 byte stream among NUM_REQ region writers.
// Optional pixel-stall timeout: define TFT_SCHED_TIMEOUT_EN.
module tft_region_scheduler #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned COLS          = 240,
    parameter int unsigned ROWS          = 320,
    parameter int unsigned TIMEOUT_TICKS = 1000000
) (
    input logic                     CLK_I,
    input logic                     RST_I,
    tft_region_scheduler_if.master  bus
);
    localparam int unsigned IW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [9:0]  COLS_L = 10'(COLS);
    localparam logic [9:0]  ROWS_L = 10'(ROWS);

    typedef enum logic [3:0] {
        IDLE, ARB, CHECK, CMD_CASET, ARG_X, CMD_PASET, ARG_Y,
        CMD_RAMWR, PIX_WAIT, PIX_HI, PIX_LO, FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [8:0]         cx0_q, cx0_d, cx1_q, cx1_d, cy0_q, cy0_d, cy1_q, cy1_d;
    logic [16:0]        npix_q, npix_d;
    logic [15:0]        word_q, word_d;
    logic [1:0]         idx_q, idx_d;
    logic               err_q, err_d;
`ifdef TFT_SCHED_TIMEOUT_EN
    logic [19:0]        to_cnt_q, to_cnt_d;
`endif

    logic               out_valid, out_dc;
    logic [7:0]         out_byte;
    logic [NUM_REQ-1:0] pix_ready, done, err;
    logic [NUM_REQ-1:0] rbits;
    logic               found;
    logic [IW-1:0]      win;
    int unsigned        cand, gsel;
    logic [9:0]         w10, h10;
    logic               bad;

    function automatic logic [7:0] arg_byte(input logic [8:0] c0, input logic [8:0] c1,
                                            input logic [1:0] i);
        case (i)
            2'd0:    arg_byte = {7'b0, c0[8]};
            2'd1:    arg_byte = c0[7:0];
            2'd2:    arg_byte = {7'b0, c1[8]};
            default: arg_byte = c1[7:0];
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cx0_d     = cx0_q;
        cx1_d     = cx1_q;
        cy0_d     = cy0_q;
        cy1_d     = cy1_q;
        npix_d    = npix_q;
        word_d    = word_q;
        idx_d     = idx_q;
        err_d     = err_q;
`ifdef TFT_SCHED_TIMEOUT_EN
        to_cnt_d  = '0;
`endif
        out_valid = 1'b0;
        out_byte  = '0;
        out_dc    = 1'b0;
        pix_ready = '0;
        done      = '0;
        err       = '0;
        rbits     = '0;
        found     = 1'b0;
        win       = '0;
        cand      = 0;
        gsel      = 32'(gidx_q);
        w10       = {1'b0, cx1_q} - {1'b0, cx0_q} + 10'd1;
        h10       = {1'b0, cy1_q} - {1'b0, cy0_q} + 10'd1;
        bad       = (cx0_q > cx1_q) || (cy0_q > cy1_q) ||
                    ({1'b0, cx1_q} >= COLS_L) || ({1'b0, cy1_q} >= ROWS_L);

        case (state_q)
            IDLE: begin
                // First requester at or after the pointer, wrapping around.
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = 32'(ptr_q) + k;
                    if (cand >= NUM_REQ) cand = cand - NUM_REQ;
                    rbits = bus.req_i >> cand;
                    if (!found && rbits[0]) begin
                        found = 1'b1;
                        win   = IW'(cand);
                    end
                end
                if (found) begin
                    gidx_d  = win;
                    gnt_d   = NUM_REQ'(1) << win;
                    err_d   = 1'b0;
                    state_d = ARB;
                end
            end
            ARB: begin
                cx0_d   = 9'(bus.x0_i >> (9 * gsel));
                cx1_d   = 9'(bus.x1_i >> (9 * gsel));
                cy0_d   = 9'(bus.y0_i >> (9 * gsel));
                cy1_d   = 9'(bus.y1_i >> (9 * gsel));
                state_d = CHECK;
            end
            CHECK: begin
                if (bad) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    npix_d  = {7'b0, w10} * {7'b0, h10};
                    state_d = CMD_CASET;
                end
            end
            CMD_CASET, CMD_PASET, CMD_RAMWR: begin
                out_valid = 1'b1;
                out_byte  = (state_q == CMD_CASET) ? 8'h2A :
                            (state_q == CMD_PASET) ? 8'h2B : 8'h2C;
                if (bus.out_ready_i) begin
                    idx_d   = '0;
                    state_d = (state_q == CMD_CASET) ? ARG_X :
                              (state_q == CMD_PASET) ? ARG_Y : PIX_WAIT;
                end
            end
            ARG_X, ARG_Y: begin
                out_valid = 1'b1;
                out_dc    = 1'b1;
                out_byte  = (state_q == ARG_X) ? arg_byte(cx0_q, cx1_q, idx_q)
                                               : arg_byte(cy0_q, cy1_q, idx_q);
                if (bus.out_ready_i) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = (state_q == ARG_X) ? CMD_PASET : CMD_RAMWR;
                end
            end
            PIX_WAIT: begin
                pix_ready = gnt_q;
                rbits     = bus.pix_valid_i >> gsel;
                if (rbits[0]) begin
                    word_d  = 16'(bus.pix_data_i >> (16 * gsel));
                    state_d = PIX_HI;
                end
`ifdef TFT_SCHED_TIMEOUT_EN
                else if (32'(to_cnt_q) + 1 >= TIMEOUT_TICKS) begin
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else begin
                    to_cnt_d = to_cnt_q + 20'd1;
                end
`endif
            end
            PIX_HI: begin
                out_valid = 1'b1;
                out_dc    = 1'b1;
                out_byte  = word_q[15:8];
                if (bus.out_ready_i) state_d = PIX_LO;
            end
            PIX_LO: begin
                out_valid = 1'b1;
                out_dc    = 1'b1;
                out_byte  = word_q[7:0];
                if (bus.out_ready_i) begin
                    npix_d  = npix_q - 17'd1;
                    state_d = (npix_q == 17'd1) ? FINISH : PIX_WAIT;
                end
            end
            FINISH: begin
                done    = gnt_q;
                err     = err_q ? gnt_q : '0;
                ptr_d   = (32'(gidx_q) + 1 >= NUM_REQ) ? '0 : gidx_q + IW'(1);
                gnt_d   = '0;
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= IDLE;
            gnt_q    <= '0;
            gidx_q   <= '0;
            ptr_q    <= '0;
            cx0_q    <= '0;
            cx1_q    <= '0;
            cy0_q    <= '0;
            cy1_q    <= '0;
            npix_q   <= '0;
            word_q   <= '0;
            idx_q    <= '0;
            err_q    <= 1'b0;
`ifdef TFT_SCHED_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gidx_q   <= gidx_d;
            ptr_q    <= ptr_d;
            cx0_q    <= cx0_d;
            cx1_q    <= cx1_d;
            cy0_q    <= cy0_d;
            cy1_q    <= cy1_d;
            npix_q   <= npix_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
`ifdef TFT_SCHED_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
`endif
        end
    end

    assign bus.out_valid_o = out_valid;
    assign bus.out_byte_o  = out_byte;
    assign bus.out_dc_o    = out_dc;
    assign bus.pix_ready_o = pix_ready;
    assign bus.gnt_o       = gnt_q;
    assign bus.done_o      = done;
    assign bus.err_o       = err;
    assign bus.busy_o      = (state_q != IDLE);
endmodule
